// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle shift-add multiplier / restoring divider.
// One iteration per clock, WIDTH iterations per operation. Busy stalls the
// pipeline while the unit works, and Done pulses for one cycle with the results.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Two's-complement negation of an operand-width value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CW-1:0]      count_r;
    logic [1:0]         op_r;
    // mcand_r holds the multiplicand (multiply) or divisor (divide) magnitude.
    logic [WIDTH-1:0]   mcand_r;
    // hi_r: product upper half / partial remainder.
    // lo_r: multiplier shifting out / dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   op1_raw_r;
    logic               sign_pq_r;
    logic               sign_rem_r;
    logic [WIDTH-1:0]   result1_r;
    logic [WIDTH-1:0]   result2_r;

    logic [WIDTH-1:0]   mag1_s;
    logic [WIDTH-1:0]   mag2_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s;
    logic               div_borrow_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [WIDTH-1:0]   hi_nx_s;
    logic [WIDTH-1:0]   lo_nx_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic               div0_s;
    logic               last_s;
    logic [WIDTH-1:0]   fix1_s;
    logic [WIDTH-1:0]   fix2_s;

    assign Result1 = result1_r;
    assign Result2 = result2_r;
    assign last_s  = (count_r == LAST_CNT);
    assign div0_s  = (mcand_r == {WIDTH{1'b0}});

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; Start only matters in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:    state_nx_s = Start ? S_COMPUTE : S_IDLE;
            S_COMPUTE: state_nx_s = last_s ? S_DONE : S_COMPUTE;
            S_DONE:    state_nx_s = S_IDLE;
            default:   state_nx_s = S_IDLE;
        endcase
    end

    // FSM outputs; Busy includes IDLE&Start so the stall hits the Start cycle.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_r)
            S_IDLE:    Busy = Start;
            S_COMPUTE: Busy = 1'b1;
            S_DONE:    Done = 1'b1;
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    // Operand magnitudes at load time; only signed ops take the absolute value.
    always_comb begin
        if (MCycleOp[0] && Operand1[WIDTH-1]) begin
            mag1_s = neg_w(Operand1);
        end else begin
            mag1_s = Operand1;
        end
        if (MCycleOp[0] && Operand2[WIDTH-1]) begin
            mag2_s = neg_w(Operand2);
        end else begin
            mag2_s = Operand2;
        end
    end

    // One multiply or divide iteration on the current accumulator contents.
    always_comb begin
        mul_sum_s    = {1'b0, hi_r};
        div_sh_s     = {hi_r, lo_r[WIDTH-1]};
        // Borrow of the 33-bit trial subtraction shifted_remainder - divisor.
        div_borrow_s = (div_sh_s < {1'b0, mcand_r});
        // When there is no borrow the difference is below the divisor, so it fits.
        div_diff_s   = div_sh_s[WIDTH-1:0] - mcand_r;
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        if (op_r[1]) begin
            if (div_borrow_s) begin
                hi_nx_s = div_sh_s[WIDTH-1:0];
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_nx_s = div_diff_s;
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (lo_r[0]) begin
                mul_sum_s = {1'b0, hi_r} + {1'b0, mcand_r};
            end else begin
                mul_sum_s = {1'b0, hi_r};
            end
            hi_nx_s = mul_sum_s[WIDTH:1];
            lo_nx_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the final iteration's values; divide-by-zero overrides.
    always_comb begin
        prod_neg_s = neg_2w({hi_nx_s, lo_nx_s});
        fix1_s     = lo_nx_s;
        fix2_s     = hi_nx_s;
        case (op_r)
            2'b00: begin
                fix1_s = lo_nx_s;
                fix2_s = hi_nx_s;
            end
            2'b01: begin
                if (sign_pq_r) begin
                    fix1_s = prod_neg_s[WIDTH-1:0];
                    fix2_s = prod_neg_s[2*WIDTH-1:WIDTH];
                end else begin
                    fix1_s = lo_nx_s;
                    fix2_s = hi_nx_s;
                end
            end
            2'b10: begin
                if (div0_s) begin
                    fix1_s = {WIDTH{1'b1}};
                    fix2_s = op1_raw_r;
                end else begin
                    fix1_s = lo_nx_s;
                    fix2_s = hi_nx_s;
                end
            end
            2'b11: begin
                if (div0_s) begin
                    fix1_s = {WIDTH{1'b1}};
                    fix2_s = op1_raw_r;
                end else begin
                    fix1_s = sign_pq_r  ? neg_w(lo_nx_s) : lo_nx_s;
                    fix2_s = sign_rem_r ? neg_w(hi_nx_s) : hi_nx_s;
                end
            end
            default: begin
                fix1_s = lo_nx_s;
                fix2_s = hi_nx_s;
            end
        endcase
    end

    // Operand latch on accepted Start, then per-cycle iteration in COMPUTE.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            count_r    <= {CW{1'b0}};
            op_r       <= 2'b00;
            mcand_r    <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            op1_raw_r  <= {WIDTH{1'b0}};
            sign_pq_r  <= 1'b0;
            sign_rem_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (Start) begin
                        op_r       <= MCycleOp;
                        count_r    <= {CW{1'b0}};
                        hi_r       <= {WIDTH{1'b0}};
                        op1_raw_r  <= Operand1;
                        sign_pq_r  <= Operand1[WIDTH-1] ^ Operand2[WIDTH-1];
                        sign_rem_r <= Operand1[WIDTH-1];
                        if (MCycleOp[1]) begin
                            mcand_r <= mag2_s;
                            lo_r    <= mag1_s;
                        end else begin
                            mcand_r <= mag1_s;
                            lo_r    <= mag2_s;
                        end
                    end
                end
                S_COMPUTE: begin
                    hi_r    <= hi_nx_s;
                    lo_r    <= lo_nx_s;
                    count_r <= count_r + 1'b1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Result registers change only on the COMPUTE->DONE edge, never mid-operation.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            result1_r <= {WIDTH{1'b0}};
            result2_r <= {WIDTH{1'b0}};
        end else if (state_r == S_COMPUTE && last_s) begin
            result1_r <= fix1_s;
            result2_r <= fix2_s;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a driver issues operations and pushes
// expected results from a plain-arithmetic model; a negedge monitor checks
// Busy every cycle, results holding, and each Done against the queue.
module tb_mul_div_unit;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    mul_div_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          win_start = -100;
    int          win_end = -100;
    logic [31:0] hold1 = 32'h0;
    logic [31:0] hold2 = 32'h0;
    bit          chk_en = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {Result2, Result1} from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb2;
        longint q;
        longint r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (op)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = 64'(sa * sb2);
            2'b10: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb2;
                    r = sa % sb2;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive a one-cycle Start; scramble inputs afterwards to catch re-sampling.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit accept);
        logic [63:0] e;
        exp_t        x;
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        if (accept) begin
            e     = model(op, a, b);
            x.r1  = e[31:0];
            x.r2  = e[63:32];
            x.cyc = cyc + 33;
            sb.push_back(x);
            win_start = cyc;
            win_end   = cyc + 32;
        end
        tick(1);
        Start    = 1'b0;
        MCycleOp = 2'($urandom_range(0, 3));
        Operand1 = $urandom;
        Operand2 = $urandom;
    endtask

    // Monitor: Busy window, Done against scoreboard, results holding otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("busy", 64'(Busy), 64'(cyc >= win_start && cyc <= win_end));
                if (Done) begin
                    chk("done_vs_busy", 64'(Busy), 64'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'(Done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(e.cyc));
                        hold1 = e.r1;
                        hold2 = e.r2;
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                    chk("missing_done", 64'(Done), 64'd1);
                    e = sb.pop_front();
                    hold1 = e.r1;
                    hold2 = e.r2;
                end
                chk("result1", 64'(Result1), 64'(hold1));
                chk("result2", 64'(Result2), 64'(hold2));
            end
        end
    end

    initial begin
        int c;
        Reset    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        tick(3);
        Reset  = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // Directed vectors, issued back to back at the earliest restart cycle.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); tick(33);
        issue(2'b01, 32'hFFFF_FFF9, 32'h0000_0006, 1'b1); tick(33);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1); tick(33);
        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1); tick(33);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); tick(33);
        issue(2'b10, 32'd100,       32'h0000_0000, 1'b1); tick(33);
        issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1); tick(33);
        issue(2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1); tick(33);
        issue(2'b00, 32'h0000_0000, 32'h1234_5678, 1'b1); tick(40);

        // Restart filtering: Starts in cycle 5 and in DONE are ignored.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1); tick(4);
        issue(2'b01, $urandom, $urandom, 1'b0);           tick(27);
        issue(2'b10, $urandom, $urandom, 1'b0);
        issue(2'b11, 32'hFFFF_FF9C, 32'h0000_0007, 1'b1); tick(36);

        // Reset in cycle 10 of a running operation aborts it.
        c = cyc;
        issue(2'b01, 32'h0BAD_F00D, 32'hFEDC_BA98, 1'b1); tick(9);
        Reset = 1'b1;
        sb.delete();
        win_end = c + 10;
        tick(1);
        Reset = 1'b0;
        hold1 = 32'h0;
        hold2 = 32'h0;
        tick(40);
        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1); tick(36);

        // Randomized operations, some with idle gaps in between.
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
            tick(33 + $urandom_range(0, 2));
        end

        tick(5);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
